// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Optional carry chaining is enabled with the ADDARB_CHAIN_EN macro.
package adder_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Response register layout at the default widths.
  typedef struct packed {
    logic [id_width(NREQ_DEF)-1:0] id;
    logic [WIDTH_DEF-1:0]          sum;
    logic                          cout;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first set request at or after ptr_i,
// searching circularly. gnt_o is forced to zero when en_i is low.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = idx;
        gnt_o[idx] = en_i;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters, with a
// one-deep tagged response slot. ADDARB_CHAIN_EN adds per-requester stored carries.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0]             req_cin,
  input  logic [NREQ-1:0]             req_chain,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_cout
);

  localparam int IDW = id_width(NREQ);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } slot_t;

  slot_state_e     state_q, state_d;
  slot_t           rsp_q, rsp_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            can_accept;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            cin_eff;
  logic [WIDTH:0]  full_sum;

  // Handshake: a transfer happens on a clock edge where valid & ready; ready never
  // looks at the payload, and a valid side holds its payload until that edge.
  assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready;
  assign req_ready  = gnt;
  assign accept     = |gnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (can_accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

`ifdef ADDARB_CHAIN_EN
  logic [NREQ-1:0] cst_q, cst_d;

  assign cin_eff = req_chain[gnt_idx] ? cst_q[gnt_idx] : req_cin[gnt_idx];

  always_comb begin
    cst_d = cst_q;
    if (accept) cst_d[gnt_idx] = full_sum[WIDTH];
  end
`else
  logic unused_chain;

  assign unused_chain = ^req_chain;
  assign cin_eff      = req_cin[gnt_idx];
`endif

  assign full_sum = {1'b0, req_a[gnt_idx]} + {1'b0, req_b[gnt_idx]} + {{WIDTH{1'b0}}, cin_eff};

  // An accept always wins over a drain, so a simultaneous drain+accept keeps the slot full.
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d    = SLOT_FULL;
      rsp_d.id   = gnt_idx;
      rsp_d.sum  = full_sum[WIDTH-1:0];
      rsp_d.cout = full_sum[WIDTH];
      ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      rsp_q   <= '0;
      ptr_q   <= '0;
`ifdef ADDARB_CHAIN_EN
      cst_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      ptr_q   <= ptr_d;
`ifdef ADDARB_CHAIN_EN
      cst_q   <= cst_d;
`endif
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter; expected chain results follow ADDARB_CHAIN_EN.
module tb_adder_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_cin;
  logic [NREQ-1:0]            req_chain;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [1:0]                 rsp_id;
  logic [WIDTH-1:0]           rsp_sum;
  logic                       rsp_cout;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];  // {id, cout, sum}

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic chain);
    req_a[i]     = a;
    req_b[i]     = b;
    req_cin[i]   = cin;
    req_chain[i] = chain;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic cout, input logic [31:0] sum);
    exp_q.push_back({id, cout, sum});
  endtask

  task automatic check_rsp(input string tag);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
      check({tag, "_id"},    64'(rsp_id),    64'(e[34:33]));
      check({tag, "_cout"},  64'(rsp_cout),  64'(e[32]));
      check({tag, "_sum"},   64'(rsp_sum),   64'(e[31:0]));
    end
  endtask

  logic [1:0]  contend_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] contend_sum [6] = '{32'h101, 32'h102, 32'h103, 32'h105, 32'h101, 32'h102};
  logic [1:0]  sparse_id   [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
  logic [31:0] sparse_sum  [4] = '{32'h33, 32'h44, 32'h33, 32'h44};
  logic [31:0] chain_sum;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
    rsp_ready = 1'b0;
`ifdef ADDARB_CHAIN_EN
    chain_sum = 32'h1;
`else
    chain_sum = 32'h0;
`endif
    #12;
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_sum",   64'(rsp_sum),   64'(0));
    check("rst_cout",  64'(rsp_cout),  64'(0));
    check("rst_id",    64'(rsp_id),    64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    tick();
    rst_n = 1'b1;

    // Single requester, carry out of the top bit
    rsp_ready = 1'b1;
    set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1 check("single_ready", 64'(req_ready), 64'(4'b0001));
    expect_rsp(2'd0, 1'b1, 32'h0);
    tick();
    req_valid = '0;
    check_rsp("single");
    tick();
    check("drain_valid", 64'(rsp_valid), 64'(0));

    // Full contention from a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'h100, (i == 3), 1'b0);
    for (int n = 0; n < 6; n++) begin
      #1 check("contend_ready", 64'(req_ready), 64'(4'b0001 << contend_id[n]));
      expect_rsp(contend_id[n], 1'b0, contend_sum[n]);
      tick();
      check_rsp("contend");
    end

    // Backpressure: slot holds id1/0x102, ptr=2, req1 waits with a new op
    req_valid = 4'b0010;
    req_a[1]  = 32'h7;
    req_b[1]  = 32'h8;
    req_cin[1] = 1'b0;
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 check("bp_ready", 64'(req_ready), 64'(0));
      tick();
      check("bp_valid", 64'(rsp_valid), 64'(1));
      check("bp_id",    64'(rsp_id),    64'(1));
      check("bp_sum",   64'(rsp_sum),   64'(32'h102));
      check("bp_cout",  64'(rsp_cout),  64'(0));
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'(4'b0010));
    expect_rsp(2'd1, 1'b0, 32'hF);
    tick();
    req_valid = '0;
    check_rsp("bp_reload");

    // Carry chain across an interleaved requester (ptr=2)
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1 check("chain0_ready", 64'(req_ready), 64'(4'b0100));
    expect_rsp(2'd2, 1'b1, 32'h0);
    tick();
    req_valid = '0;
    check_rsp("chain0");
    set_req(1, 32'h5, 32'h6, 1'b0, 1'b0);
    #1 check("chain_mid_ready", 64'(req_ready), 64'(4'b0010));
    expect_rsp(2'd1, 1'b0, 32'hB);
    tick();
    req_valid = '0;
    check_rsp("chain_mid");
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b1);
    #1 check("chain1_ready", 64'(req_ready), 64'(4'b0100));
    expect_rsp(2'd2, 1'b0, chain_sum);
    tick();
    req_valid = '0;
    req_chain = '0;
    check_rsp("chain1");

    // Sparse wrap: move ptr to 1 via req0, then only 3 and 0 valid
    set_req(0, 32'h10, 32'h20, 1'b0, 1'b0);
    expect_rsp(2'd0, 1'b0, 32'h30);
    tick();
    req_valid = '0;
    check_rsp("sparse_setup");
    set_req(3, 32'h30, 32'h3, 1'b0, 1'b0);
    set_req(0, 32'h40, 32'h4, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      #1 check("sparse_ready", 64'(req_ready), 64'(4'b0001 << sparse_id[n]));
      expect_rsp(sparse_id[n], 1'b0, sparse_sum[n]);
      tick();
      check_rsp("sparse");
    end
    req_valid = '0;

    // Reset while the slot is full and ptr=3
    set_req(2, 32'h2, 32'h2, 1'b1, 1'b0);
    expect_rsp(2'd2, 1'b0, 32'h5);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    check_rsp("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'(0));
    check("midrst_sum",   64'(rsp_sum),   64'(0));
    check("midrst_id",    64'(rsp_id),    64'(0));
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'hA0 + 32'(i), 32'h0, 1'b0, 1'b0);
    #1 check("post_reset_ready", 64'(req_ready), 64'(4'b0001));
    expect_rsp(2'd0, 1'b0, 32'hA0);
    tick();
    req_valid = '0;
    check_rsp("post_reset");
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
